alu_result_sel_pipe: RTL and testbench
======================================

Name: alu_result_sel_pipe

Overview:
- Parametrised, registered N-way result selector for the full ALU output stage.
- Picks one of NUM_IN operation results with a full-width select, and registers the result behind a valid/ready handshake so the ALU can stall.
- Flags and counts out-of-range selects instead of aliasing them onto legal channels.
- Sits between the per-operation ALU units and the writeback/bypass logic.

Parameters:
- WIDTH, 32: data width per channel.
- NUM_IN, 6: number of selectable channels, 2..32.
- SEL_W, 5: select width; must satisfy 2^SEL_W >= NUM_IN.
- ERR_CNT_W, 8: width of the illegal-select counter.

Ports:
- clock, in, 1: single clock; all state updates on rising edge.
- reset, in, 1: synchronous, active-high reset.
- in_data, in, NUM_IN*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- in_sel, in, SEL_W: channel select, decoded on all SEL_W bits.
- in_valid, in, 1: in_data/in_sel are valid this cycle.
- in_ready, out, 1: stage can accept a transfer this cycle.
- out_data, out, WIDTH: registered selected result.
- out_sel, out, SEL_W: select that produced out_data.
- out_illegal, out, 1: out_data came from an out-of-range select.
- out_valid, out, 1: out_data/out_sel/out_illegal are valid.
- out_ready, in, 1: downstream accepts this cycle.
- err_sticky, out, 1: set by any accepted illegal select.
- err_count, out, ERR_CNT_W: saturating count of accepted illegal selects.
- err_clr, in, 1: clears err_sticky and err_count.

Behaviour:
- Reset (synchronous, active-high, sampled at clock edge) clears out_data, out_sel, out_illegal, out_valid, err_sticky and err_count to 0. in_ready is 1 during the reset cycle's aftermath: the first cycle after reset deasserts, in_ready=1.
- An in-flight output is discarded on reset, with no completion.
- Decode:
  - sel < NUM_IN selects channel sel.
  - sel >= NUM_IN produces all-zero data with illegal=1.
  - No partial-bit decode: e.g. sel=8 with NUM_IN=6 never aliases to channel 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. On accept, out_data/out_sel/out_illegal load next edge and out_valid=1.
  - Latency: 1 cycle from accept to out_valid.
  - Throughput: 1 per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, output registers hold stable and in_ready=0. Input is ignored, not lost, because the source must hold it.
- Drain: if out_valid && out_ready && !(in_valid), out_valid clears next edge and out_data holds its last value.
- Simultaneous drain and accept: the new item replaces the old one, and out_valid stays 1.
- Error counters:
  - err_count and err_sticky update only on an accepted illegal transfer; rejected or stalled inputs do not count.
  - err_count saturates at 2^ERR_CNT_W-1.
  - If err_clr and an accepted illegal transfer occur in the same cycle, clear wins; the result is 0 with sticky 0, and the illegal item itself still carries out_illegal=1.
- in_sel/in_data are don't-care when in_valid=0; no state changes.

Test Plan:
- Reset behaviour: assert reset 2 cycles with in_valid=1, then release -> all outputs 0, and in_ready=1 after release.
- Legal sweep, NUM_IN=6, channel k data = 32'h1000_0000+k, sel 0..5 back-to-back, out_ready=1 -> out_data = 1000_0000..1000_0005 on consecutive cycles, 1 cycle after each accept, out_illegal=0.
- Illegal selects:
  - sel=6, 7, 8, 31 -> out_data=0, out_illegal=1, err_count 1,2,3,4, err_sticky=1.
  - sel=8 must not return channel 0.
- Backpressure:
  - Accept sel=2, then hold out_ready=0 for 3 cycles with in_valid=1 sel=4 -> out_data stays 1000_0002 and in_ready=0.
  - Raise out_ready -> the next cycle shows 1000_0004, with no item dropped or duplicated.
- Saturation and clear:
  - ERR_CNT_W=2, 5 accepted illegals -> err_count stops at 3.
  - err_clr together with an illegal accept -> err_count=0, err_sticky=0, out_illegal=1.
- Mid-operation reset: reset while out_valid=1 and out_ready=0 -> out_valid=0 next edge, and the item is never delivered.

Source files
------------

// File: rtl/alu_result_sel_pipe.sv
// alu_result_sel_pipe
// Registered N-way result selector for the ALU output stage. One of NUM_IN
// operation results is chosen by a full-width select and held in an output
// register behind a valid/ready handshake so the ALU can be stalled.
// Out-of-range selects return all-zero data, are flagged with out_illegal,
// and are recorded in a sticky flag and a saturating counter.
//
// Ports:
//   clock, reset              single clock, synchronous active-high reset
//   in_data[NUM_IN*WIDTH]     channel k at bits [k*WIDTH +: WIDTH]
//   in_sel, in_valid          select and qualifier for the current transfer
//   in_ready                  stage can accept this cycle
//   out_data/out_sel          registered result and the select that made it
//   out_illegal               result came from an out-of-range select
//   out_valid, out_ready      output handshake
//   err_sticky, err_count     illegal-select history; err_clr clears both
module alu_result_sel_pipe #(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 6,
  parameter int SEL_W     = 5,
  parameter int ERR_CNT_W = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_illegal,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_sticky,
  output logic [ERR_CNT_W-1:0]    err_count,
  input  logic                    err_clr
);

  // One extra bit so NUM_IN == 2^SEL_W is still representable.
  localparam logic [SEL_W:0] num_in_l = (SEL_W+1)'(NUM_IN);

  logic             accept;
  logic             sel_legal;
  logic [WIDTH-1:0] sel_data;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign sel_legal = {1'b0, in_sel} < num_in_l;

  // Full-width compare per channel: an out-of-range select matches nothing
  // and leaves sel_data at zero, so no low-bit aliasing is possible.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if ({1'b0, in_sel} == (SEL_W+1)'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data    <= '0;
      out_sel     <= '0;
      out_illegal <= 1'b0;
      out_valid   <= 1'b0;
    end else if (accept) begin
      out_data    <= sel_legal ? sel_data : '0;
      out_sel     <= in_sel;
      out_illegal <= !sel_legal;
      out_valid   <= 1'b1;
    end else if (out_ready) begin
      // No accept with out_ready high means no input: drain, data holds.
      out_valid   <= 1'b0;
    end
  end

  // Clear has priority over a coincident illegal accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (accept && !sel_legal) begin
      err_sticky <= 1'b1;
      if (err_count != '1) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Directed bench for alu_result_sel_pipe. A second instance with a 2-bit
// error counter shares all stimulus so saturation can be observed alongside
// the normal-width counter.
module tb_alu_result_sel_pipe;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 6;
  localparam int SEL_W  = 5;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    out_ready;
  logic                    err_clr;

  logic                    in_ready,    in_ready2;
  logic [WIDTH-1:0]        out_data,    out_data2;
  logic [SEL_W-1:0]        out_sel,     out_sel2;
  logic                    out_illegal, out_illegal2;
  logic                    out_valid,   out_valid2;
  logic                    err_sticky,  err_sticky2;
  logic [7:0]              err_count;
  logic [1:0]              err_count2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_result_sel_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .ERR_CNT_W(8)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_illegal(out_illegal), .out_valid(out_valid),
    .out_ready(out_ready), .err_sticky(err_sticky), .err_count(err_count),
    .err_clr(err_clr)
  );

  alu_result_sel_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .ERR_CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready2), .out_data(out_data2),
    .out_sel(out_sel2), .out_illegal(out_illegal2), .out_valid(out_valid2),
    .out_ready(out_ready), .err_sticky(err_sticky2), .err_count(err_count2),
    .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int ill_sel [5] = '{6, 7, 8, 31, 9};
    for (int k = 0; k < NUM_IN; k++) begin
      in_data[k*WIDTH +: WIDTH] = 32'h1000_0000 + k;
    end
    reset = 1'b1; in_valid = 1'b1; in_sel = '0; out_ready = 1'b1; err_clr = 1'b0;

    // reset held 2 cycles with in_valid high
    step(); step();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_illegal", out_illegal, 0);
    check("rst_count", err_count, 0);
    check("rst_sticky", err_sticky, 0);
    reset = 1'b0; in_valid = 1'b0;
    step();
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_sel", out_sel, 0);

    // legal sweep, back to back
    for (int k = 0; k < NUM_IN; k++) begin
      in_valid = 1'b1; in_sel = SEL_W'(k);
      step();
      check($sformatf("legal%0d_valid", k), out_valid, 1);
      check($sformatf("legal%0d_data", k), out_data, 32'h1000_0000 + k);
      check($sformatf("legal%0d_sel", k), out_sel, k);
      check($sformatf("legal%0d_illegal", k), out_illegal, 0);
    end
    in_valid = 1'b0;
    step();
    check("drain_valid", out_valid, 0);
    check("drain_data_hold", out_data, 32'h1000_0005);

    // illegal selects; second instance saturates at 3
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sel = SEL_W'(ill_sel[i]);
      step();
      check($sformatf("ill%0d_data", ill_sel[i]), out_data, 0);
      check($sformatf("ill%0d_flag", ill_sel[i]), out_illegal, 1);
      check($sformatf("ill%0d_sel", ill_sel[i]), out_sel, ill_sel[i]);
      check($sformatf("ill%0d_count", ill_sel[i]), err_count, i + 1);
      check($sformatf("ill%0d_sticky", ill_sel[i]), err_sticky, 1);
      check($sformatf("ill%0d_count_sat", ill_sel[i]), err_count2, (i + 1 > 3) ? 3 : i + 1);
    end

    // clear coincident with an illegal accept
    in_sel = 5'd6; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_count", err_count, 0);
    check("clr_count_sat", err_count2, 0);
    check("clr_sticky", err_sticky, 0);
    check("clr_illegal", out_illegal, 1);
    check("clr_valid", out_valid, 1);

    // backpressure
    in_sel = 5'd2;
    step();
    check("bp_first", out_data, 32'h1000_0002);
    out_ready = 1'b0; in_sel = 5'd4;
    #1;
    check("bp_ready_low", in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("bp_hold%0d_data", c), out_data, 32'h1000_0002);
      check($sformatf("bp_hold%0d_ready", c), in_ready, 0);
      check($sformatf("bp_hold%0d_valid", c), out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    step();
    check("bp_next_data", out_data, 32'h1000_0004);
    check("bp_next_sel", out_sel, 4);
    in_valid = 1'b0;
    step();
    check("bp_no_dup", out_valid, 0);

    // stalled illegal input must not count
    in_valid = 1'b1; in_sel = 5'd1;
    step();
    out_ready = 1'b0; in_sel = 5'd7;
    step(); step();
    check("stall_ill_count", err_count, 0);
    check("stall_ill_sticky", err_sticky, 0);
    check("stall_ill_data", out_data, 32'h1000_0001);

    // mid-operation reset discards the held item
    reset = 1'b1;
    step();
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("midrst_no_deliver", out_valid, 0);
    check("midrst_ready", in_ready, 1);
    step();
    check("midrst_still_idle", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
